// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter
// Merges result messages from the execution-unit reservation stations onto a
// single registered completion broadcast bus. Each source owns a one-entry
// holding slot; a round-robin arbiter moves one slot per cycle into an output
// register that honours consumer back-pressure. A flash (mispredict flush)
// empties every slot and the output register without moving the pointer.
//
// Build option: define RESULT_BUS_BYPASS_EN to let a slot that is being
// drained accept new data in the same cycle (full-rate single-source
// streaming, at the cost of a combinational cdb_reject -> src_reject path).
// With the macro undefined, src_reject comes straight from the slot flops.

module result_bus_arbiter #(
    parameter int N_SRC = 4,
    parameter int MSG_W = 64,
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flash,
    input  logic [N_SRC-1:0]       src_en,
    input  logic [N_SRC*MSG_W-1:0] src_msg,
    output logic [N_SRC-1:0]       src_reject,
    output logic                   cdb_en,
    output logic [MSG_W-1:0]       cdb_msg,
    output logic [IDX_W-1:0]       cdb_src,
    input  logic                   cdb_reject
);

    // Modular add used for the round-robin search and pointer advance
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int               step);
        int sum;
        sum = int'(base) + step;
        if (sum >= N_SRC) begin
            sum = sum - N_SRC;
        end
        return sum[IDX_W-1:0];
    endfunction

    logic [N_SRC-1:0] slot_valid_q;
    logic [N_SRC-1:0] slot_valid_d;
    logic [MSG_W-1:0] slot_msg_q [N_SRC];
    logic [MSG_W-1:0] slot_msg_d [N_SRC];
    logic             out_valid_q;
    logic             out_valid_d;
    logic [MSG_W-1:0] out_msg_q;
    logic [MSG_W-1:0] out_msg_d;
    logic [IDX_W-1:0] out_src_q;
    logic [IDX_W-1:0] out_src_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic             grant;
    logic [N_SRC-1:0] accept;

    // Round-robin search: first valid slot starting at the pointer
    always_comb begin
        logic [IDX_W-1:0] cand;
        winner    = rr_ptr_q;
        any_valid = 1'b0;
        cand      = rr_ptr_q;
        for (int off = 0; off < N_SRC; off++) begin
            cand = wrap_add(rr_ptr_q, off);
            if (!any_valid && slot_valid_q[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign grant = any_valid & (~out_valid_q | ~cdb_reject) & ~flash;

`ifdef RESULT_BUS_BYPASS_EN
    // A slot being drained this cycle can be refilled in the same cycle
    always_comb begin
        src_reject = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_reject[i] = slot_valid_q[i] & ~(grant && (winner == IDX_W'(i)));
        end
    end
`else
    assign src_reject = slot_valid_q;
`endif

    assign accept = src_en & ~src_reject & {N_SRC{~flash}};

    // Next-state for slots, output register and round-robin pointer
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_msg_d   = slot_msg_q;
        out_valid_d  = out_valid_q;
        out_msg_d    = out_msg_q;
        out_src_d    = out_src_q;
        rr_ptr_d     = rr_ptr_q;
        if (flash) begin
            slot_valid_d = '0;
            out_valid_d  = 1'b0;
        end else begin
            if (grant) begin
                out_valid_d          = 1'b1;
                out_msg_d            = slot_msg_q[winner];
                out_src_d            = winner;
                slot_valid_d[winner] = 1'b0;
                rr_ptr_d             = wrap_add(winner, 1);
            end else if (out_valid_q && !cdb_reject) begin
                out_valid_d = 1'b0;
            end
            // Accept after the drain so a same-cycle refill keeps the slot valid
            for (int i = 0; i < N_SRC; i++) begin
                if (accept[i]) begin
                    slot_valid_d[i] = 1'b1;
                    slot_msg_d[i]   = src_msg[i*MSG_W +: MSG_W];
                end
            end
        end
    end

    // State registers; reset drops everything, including any in-flight message
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_valid_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                slot_msg_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int i = 0; i < N_SRC; i++) begin
                slot_msg_q[i] <= slot_msg_d[i];
            end
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign cdb_en  = out_valid_q & ~flash;
    assign cdb_msg = out_msg_q;
    assign cdb_src = out_src_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb_result_bus_arbiter
// Directed scoreboard bench: stimulus pushes hand-computed expected results
// (source, payload, broadcast cycle or -1 for don't-care) into a queue; a
// monitor pops and compares on every accepted broadcast. A driver process
// feeds per-source message queues through the src_en/src_reject handshake.

module tb_result_bus_arbiter;

    localparam int N_SRC = 4;
    localparam int MSG_W = 64;
    localparam int IDX_W = 2;
`ifdef RESULT_BUS_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [IDX_W-1:0] src;
        logic [MSG_W-1:0] msg;
        int               cyc;
    } exp_t;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   flash;
    logic [N_SRC-1:0]       src_en;
    logic [N_SRC*MSG_W-1:0] src_msg;
    logic [N_SRC-1:0]       src_reject;
    logic                   cdb_en;
    logic [MSG_W-1:0]       cdb_msg;
    logic [IDX_W-1:0]       cdb_src;
    logic                   cdb_reject;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    exp_t             exp_q [$];
    logic [MSG_W-1:0] tx_q [N_SRC][$];

    result_bus_arbiter #(.N_SRC(N_SRC), .MSG_W(MSG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .flash      (flash),
        .src_en     (src_en),
        .src_msg    (src_msg),
        .src_reject (src_reject),
        .cdb_en     (cdb_en),
        .cdb_msg    (cdb_msg),
        .cdb_src    (cdb_src),
        .cdb_reject (cdb_reject)
    );

    // Free-running clock and cycle counter
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [MSG_W-1:0] actual,
                                input logic [MSG_W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic apply_stimulus(input int src, input logic [MSG_W-1:0] msg,
                                  input int exp_cyc, input bit expect_out);
        tx_q[src].push_back(msg);
        if (expect_out) begin
            exp_q.push_back('{src: IDX_W'(src), msg: msg, cyc: exp_cyc});
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
            exp_q.delete();
        end
        step(3);
    endtask

    // Source driver: holds en/msg until a transfer, then presents the next entry
    initial begin : driver
        logic [N_SRC-1:0] xfer;
        logic [MSG_W-1:0] dropped;
        src_en  = '0;
        src_msg = '0;
        forever begin
            @(negedge clock);
            xfer = src_en & ~src_reject & {N_SRC{~flash & ~reset}};
            @(posedge clock);
            #2;
            for (int i = 0; i < N_SRC; i++) begin
                if (xfer[i] && tx_q[i].size() > 0) begin
                    dropped = tx_q[i].pop_front();
                end
                if (tx_q[i].size() > 0) begin
                    src_en[i]                  = 1'b1;
                    src_msg[i*MSG_W +: MSG_W]  = tx_q[i][0];
                end else begin
                    src_en[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard compare on each accepted broadcast, plus hold stability
    initial begin : monitor
        exp_t             e;
        logic             hold_prev = 1'b0;
        logic [MSG_W-1:0] msg_prev  = '0;
        logic [IDX_W-1:0] src_prev  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                hold_prev = 1'b0;
                continue;
            end
            if (hold_prev && cdb_en) begin
                check_output("held_msg", cdb_msg, msg_prev);
                check_output("held_src", MSG_W'(cdb_src), MSG_W'(src_prev));
            end
            if (cdb_en && !cdb_reject) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_cdb: got src %0d msg 0x%0h, expected no transfer (cycle %0d)",
                             cdb_src, cdb_msg, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check_output("cdb_src", MSG_W'(cdb_src), MSG_W'(e.src));
                    check_output("cdb_msg", cdb_msg, e.msg);
                    if (e.cyc >= 0) begin
                        check_output("cdb_cycle", MSG_W'(cyc), MSG_W'(e.cyc));
                    end
                end
            end
            hold_prev = cdb_en && cdb_reject;
            msg_prev  = cdb_msg;
            src_prev  = cdb_src;
        end
    end

    // Directed stimulus sequence
    initial begin : stimulus
        int n;
        reset      = 1'b0;
        flash      = 1'b0;
        cdb_reject = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_output("reset_cdb_en", MSG_W'(cdb_en), '0);
        check_output("reset_src_reject", MSG_W'(src_reject), '0);
        check_output("reset_cdb_msg", cdb_msg, '0);
        check_output("reset_cdb_src", MSG_W'(cdb_src), '0);
        step(2);
        reset = 1'b0;

        // Single result, two-cycle latency
        step(1);
        n = cyc;
        apply_stimulus(0, 64'hA5, n + 2, 1'b1);
        wait_drain(20);

        // Bring the pointer back to 0 via source 3
        n = cyc;
        apply_stimulus(3, 64'h33, n + 2, 1'b1);
        wait_drain(20);

        // Four-way contention, then pairs
        n = cyc;
        apply_stimulus(0, 64'h10, n + 2, 1'b1);
        apply_stimulus(1, 64'h11, n + 3, 1'b1);
        apply_stimulus(2, 64'h12, n + 4, 1'b1);
        apply_stimulus(3, 64'h13, n + 5, 1'b1);
        wait_drain(20);
        n = cyc;
        apply_stimulus(2, 64'h22, n + 2, 1'b1);
        apply_stimulus(3, 64'h23, n + 3, 1'b1);
        wait_drain(20);
        n = cyc;
        apply_stimulus(0, 64'h30, n + 2, 1'b1);
        apply_stimulus(3, 64'h31, n + 3, 1'b1);
        wait_drain(20);
        n = cyc;
        apply_stimulus(0, 64'h40, n + 2, 1'b1);
        apply_stimulus(3, 64'h41, n + 3, 1'b1);
        wait_drain(20);

        // Back-pressure for 5 cycles while source 1 sends three messages
        n = cyc;
        cdb_reject = 1'b1;
        apply_stimulus(1, 64'hB1, -1, 1'b1);
        apply_stimulus(1, 64'hB2, -1, 1'b1);
        apply_stimulus(1, 64'hB3, -1, 1'b1);
        step(4);
        @(negedge clock);
        check_output("bp_src_reject1", MSG_W'(src_reject[1]), MSG_W'(1));
        check_output("bp_cdb_en", MSG_W'(cdb_en), MSG_W'(1));
        check_output("bp_cdb_msg", cdb_msg, 64'hB1);
        step(1);
        cdb_reject = 1'b0;
        wait_drain(30);

        // Flash with slots 0 and 2 full and the output register loaded
        n = cyc;
        cdb_reject = 1'b1;
        apply_stimulus(0, 64'hF0A, -1, 1'b0);
        apply_stimulus(2, 64'hF2A, -1, 1'b0);
        apply_stimulus(2, 64'hF2B, -1, 1'b0);
        step(3);
        @(negedge clock);
        check_output("pre_flash_cdb_en", MSG_W'(cdb_en), MSG_W'(1));
        step(1);
        flash = 1'b1;
        @(negedge clock);
        check_output("flash_cdb_en", MSG_W'(cdb_en), '0);
        step(1);
        flash      = 1'b0;
        cdb_reject = 1'b0;
        apply_stimulus(3, 64'hF3, n + 7, 1'b1);
        @(negedge clock);
        check_output("post_flash_cdb_en", MSG_W'(cdb_en), '0);
        step(1);
        @(negedge clock);
        check_output("post_flash_cdb_en2", MSG_W'(cdb_en), '0);
        wait_drain(20);

        // Flash leaves the round-robin pointer alone
        n = cyc;
        apply_stimulus(1, 64'h51, n + 2, 1'b1);
        wait_drain(20);
        flash = 1'b1;
        step(1);
        flash = 1'b0;
        n = cyc;
        apply_stimulus(2, 64'h62, n + 2, 1'b1);
        apply_stimulus(0, 64'h60, n + 3, 1'b1);
        wait_drain(20);

        // Streaming from source 1
        n = cyc;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1, 64'h100 + 64'(k), BYPASS ? (n + 2 + k) : (n + 2 + 2 * k), 1'b1);
        end
        for (int j = 1; j <= 6; j++) begin
            step(1);
            @(negedge clock);
            check_output("stream_src_reject1", MSG_W'(src_reject[1]),
                         BYPASS ? '0 : MSG_W'(j % 2));
        end
        wait_drain(40);

        // Asynchronous reset between edges mid-stream
        n = cyc;
        apply_stimulus(2, 64'h71, n + 2, 1'b1);
        apply_stimulus(2, 64'h72, -1, 1'b0);
        apply_stimulus(2, 64'h73, -1, 1'b0);
        step(2);
        @(negedge clock);
        #2;
        reset = 1'b1;
        tx_q[2].delete();
        #1;
        check_output("midreset_cdb_en", MSG_W'(cdb_en), '0);
        check_output("midreset_src_reject", MSG_W'(src_reject), '0);
        check_output("midreset_cdb_msg", cdb_msg, '0);
        check_output("midreset_cdb_src", MSG_W'(cdb_src), '0);
        step(2);
        reset = 1'b0;
        step(1);
        n = cyc;
        apply_stimulus(1, 64'h81, n + 2, 1'b1);
        apply_stimulus(3, 64'h83, n + 3, 1'b1);
        wait_drain(20);

        check_output("scoreboard_empty", MSG_W'(exp_q.size()), '0);
        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound
    initial begin : watchdog
        #200000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
